i2c_target_ctrl: RTL
====================

Name: i2c_target_ctrl

Overview:
- Protocol controller FSM for the I2C target (slave) datapath.
- Consumes the synchronized SCL/SDA edge strobes and the start/stop flags.
- Drives the shift-register enable, bit counter, register pointer, memory write enable, ACK and output-enable controls.
- Sits between the synchronizer/edge-detect front end and the memory/gen_output back end. Implements the address phase, the register-pointer phase, the write burst and the read burst, with pointer auto-increment.

Parameters:
- DEV_ADDR, 7'h20: 7-bit target address compared against the first byte after START.
- NUM_REGS, 9: number of implemented registers. The pointer range is 0..NUM_REGS-1.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  sticky START flag from start_detect.
- stop  input  1  sticky STOP flag from stop_detect.
- SCL_posedge  input  1  one-cycle strobe on a synchronized SCL rise.
- SCL_negedge  input  1  one-cycle strobe on a synchronized SCL fall.
- data_in  input  8  shift register contents, MSB first received.
- bit_done  input  1  bit counter has reached 8.
- master_ack  input  1  ACK sampled from the master; 1 = ACK, 0 = NACK.
- clear_start  output  1  one-cycle pulse that clears the START flag.
- clear_stop  output  1  one-cycle pulse that clears the STOP flag.
- shift_en  output  1  enables SDA sampling into the shift register.
- count_clear  output  1  clears the bit counter.
- count_en  output  1  bit counter increments on SCL_posedge.
- ptr  output  5  current register pointer.
- ptr_load  output  1  one-cycle pulse: register select takes ptr on the next SCL_negedge.
- we  output  1  memory write enable, asserted for exactly one SCL_negedge.
- send_ack  output  1  drive SDA low for the ACK slot.
- out_en  output  1  serial read data drives SDA.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE, ptr=0, and every output is 0 except count_clear=1 and clear_stop=1, which are held for as long as reset is asserted.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
- STOP priority: if stop=1 in any state, next state=IDLE. Pulse clear_stop, count_clear and clear_start in that same cycle. STOP beats START if both are set.
- START (and repeated START) in any state:
  - next state=ADDR; pulse clear_start and count_clear.
  - ptr is retained, so write-pointer-then-repeated-START-read works.
- ADDR:
  - shift_en=1 and count_en=1.
  - When bit_done=1 and data_in[7:1]==DEV_ADDR: latch rw=data_in[0], then go to ADDR_ACK on the next SCL_negedge.
  - Address mismatch: go to WAIT_STOP with no ACK.
- ADDR_ACK:
  - send_ack=1 from the entry SCL_negedge until the next SCL_negedge, i.e. one full SCL low-high-low period. count_clear pulses at entry.
  - On exit: rw=0 goes to PTR; rw=1 goes to RDATA. On the RDATA path, out_en rises in the same cycle send_ack falls.
- PTR:
  - Shift 8 bits. At bit_done, if data_in < NUM_REGS: ptr <= data_in[4:0], pulse ptr_load, go to PTR_ACK.
  - Otherwise go to WAIT_STOP (NACK); ptr is unchanged.
- PTR_ACK: identical ACK timing to ADDR_ACK, then go to WDATA.
- WDATA: shift 8 bits. At bit_done, go to WDATA_ACK.
- WDATA_ACK:
  - send_ack=1 for the slot; we=1 on the entry SCL_negedge only, writing data_in to ptr.
  - On exit: ptr <= (ptr==NUM_REGS-1) ? 0 : ptr+1, pulse ptr_load, go to WDATA.
- RDATA: out_en=1 and count_en=1 on SCL_posedge. After the 8th bit, at the SCL_negedge, go to RACK with out_en=0 so SDA is released.
- RACK:
  - master_ack is sampled on the SCL_posedge.
  - ACK: at the SCL_negedge, increment ptr with the same wrap rule as writes, pulse ptr_load, count_clear, go to RDATA.
  - NACK: go to WAIT_STOP.
- WAIT_STOP: all drive outputs are 0; leave only on STOP or START.
- send_ack and out_en are never both 1. we is never 1 outside WDATA_ACK.
- ptr arithmetic is 5-bit; wrap-around is explicit at NUM_REGS-1, never at 31.
- Reset asserted mid-transfer: all outputs drop asynchronously and SDA is released within the same cycle.

Test Plan:
- Write burst: START, 0x40 (addr 0x20, W), ptr 0x02, data 0xA5, 0x3C, STOP.
  - ACK after every byte; we pulses twice; reg2=0xA5, reg3=0x3C; ptr=4 after STOP.
- Random read via repeated START: START, 0x40, ptr 0x01, repeated START, 0x41, read 2 bytes (ACK then NACK), STOP.
  - out_en serializes reg1 then reg2 MSB first; WAIT_STOP after the NACK; ptr=3.
- Address mismatch: START, 0x42.
  - send_ack stays 0; FSM sits in WAIT_STOP; a later STOP returns it to IDLE, busy=0.
- Wrap and range:
  - ptr 0x08 followed by 2 data bytes writes reg8 then reg0.
  - ptr 0x09 gets NACK; no we pulse.
- Reset and STOP mid-transfer:
  - Assert reset during WDATA bit 4: outputs 0 immediately, state IDLE, no write occurs.
  - A STOP during PTR returns the FSM to IDLE with ptr unchanged.

Source files
------------

// File: rtl/i2c_target_ctrl.sv
// I2C target protocol FSM: address, pointer, write-burst and read-burst sequencing
// driven by synchronized SCL strobes and sticky START/STOP flags.
//   state     | meaning
//   IDLE      | bus free, nothing driven
//   ADDR      | shifting the address byte
//   ADDR_ACK  | ACK slot after a matching address
//   PTR       | shifting the register pointer byte
//   PTR_ACK   | ACK slot after a valid pointer
//   WDATA     | shifting a write data byte
//   WDATA_ACK | ACK slot, memory write at entry
//   RDATA     | serializing a read byte onto SDA
//   RACK      | master ACK/NACK slot after a read byte
//   WAIT_STOP | transfer ignored until STOP or START
module i2c_target_ctrl #(
  parameter logic [6:0] DEV_ADDR = 7'h20,
  parameter int         NUM_REGS = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       SCL_posedge,
  input  logic       SCL_negedge,
  input  logic [7:0] data_in,
  input  logic       bit_done,
  input  logic       master_ack,
  output logic       clear_start,
  output logic       clear_stop,
  output logic       shift_en,
  output logic       count_clear,
  output logic       count_en,
  output logic [4:0] ptr,
  output logic       ptr_load,
  output logic       we,
  output logic       send_ack,
  output logic       out_en,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  localparam logic [4:0] LAST_PTR   = 5'(NUM_REGS - 1);
  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  state_t state;
  logic   rw;
  logic   ack_r;

  function automatic logic [4:0] ptr_next(input logic [4:0] p);
    return (p == LAST_PTR) ? 5'd0 : p + 5'd1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rw          <= 1'b0;
      ack_r       <= 1'b0;
      ptr         <= 5'd0;
      clear_start <= 1'b0;
      clear_stop  <= 1'b1;
      count_clear <= 1'b1;
      shift_en    <= 1'b0;
      count_en    <= 1'b0;
      ptr_load    <= 1'b0;
      we          <= 1'b0;
      send_ack    <= 1'b0;
      out_en      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      clear_start <= 1'b0;
      clear_stop  <= 1'b0;
      count_clear <= 1'b0;
      ptr_load    <= 1'b0;
      we          <= 1'b0;
      if (stop) begin
        state       <= IDLE;
        clear_stop  <= 1'b1;
        clear_start <= 1'b1;
        count_clear <= 1'b1;
        shift_en    <= 1'b0;
        count_en    <= 1'b0;
        send_ack    <= 1'b0;
        out_en      <= 1'b0;
        busy        <= 1'b0;
      end else if (start) begin
        // ptr is kept so a repeated START can read from the pointer just written
        state       <= ADDR;
        clear_start <= 1'b1;
        count_clear <= 1'b1;
        shift_en    <= 1'b1;
        count_en    <= 1'b1;
        send_ack    <= 1'b0;
        out_en      <= 1'b0;
        busy        <= 1'b1;
      end else begin
        case (state)
          ADDR: if (SCL_negedge && bit_done) begin
            shift_en <= 1'b0;
            count_en <= 1'b0;
            if (data_in[7:1] == DEV_ADDR) begin
              rw          <= data_in[0];
              send_ack    <= 1'b1;
              count_clear <= 1'b1;
              state       <= ADDR_ACK;
            end else begin
              state <= WAIT_STOP;
            end
          end
          ADDR_ACK: if (SCL_negedge) begin
            send_ack <= 1'b0;
            count_en <= 1'b1;
            if (rw) begin
              out_en <= 1'b1;
              state  <= RDATA;
            end else begin
              shift_en <= 1'b1;
              state    <= PTR;
            end
          end
          PTR: if (SCL_negedge && bit_done) begin
            shift_en <= 1'b0;
            count_en <= 1'b0;
            if ({1'b0, data_in} < NUM_REGS_W) begin
              ptr         <= data_in[4:0];
              ptr_load    <= 1'b1;
              send_ack    <= 1'b1;
              count_clear <= 1'b1;
              state       <= PTR_ACK;
            end else begin
              state <= WAIT_STOP;
            end
          end
          PTR_ACK: if (SCL_negedge) begin
            send_ack <= 1'b0;
            shift_en <= 1'b1;
            count_en <= 1'b1;
            state    <= WDATA;
          end
          WDATA: if (SCL_negedge && bit_done) begin
            shift_en    <= 1'b0;
            count_en    <= 1'b0;
            we          <= 1'b1;
            send_ack    <= 1'b1;
            count_clear <= 1'b1;
            state       <= WDATA_ACK;
          end
          WDATA_ACK: if (SCL_negedge) begin
            send_ack <= 1'b0;
            ptr      <= ptr_next(ptr);
            ptr_load <= 1'b1;
            shift_en <= 1'b1;
            count_en <= 1'b1;
            state    <= WDATA;
          end
          RDATA: if (SCL_negedge && bit_done) begin
            out_en   <= 1'b0;
            count_en <= 1'b0;
            state    <= RACK;
          end
          RACK: begin
            if (SCL_posedge) ack_r <= master_ack;
            // the pointer advances past every byte clocked out, ACKed or not
            if (SCL_negedge) begin
              ptr      <= ptr_next(ptr);
              ptr_load <= 1'b1;
              if (ack_r) begin
                count_clear <= 1'b1;
                out_en      <= 1'b1;
                count_en    <= 1'b1;
                state       <= RDATA;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
